// File: rtl/mem_lsu_pkg.sv
// Shared encodings and helpers for the mem_lsu load/store unit.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Size 2'b11 is not a sub-word size, so it falls through to the word path.
  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) || (size[1] && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
module lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    rdata = rd;
    case (size)
      SZ_BYTE: rdata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: rdata = rd;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit driving a word-only memory; sub-word stores use read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests return resp_err without touching memory.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              trap;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;
  logic [31:0]       rdata_q;
  logic [31:0]       lane_rdata;
  logic [31:0]       lane_merged;
  logic              word_store;

  assign accept     = req_valid && (state == ST_IDLE);
  assign word_store = we_q && !is_subword(size_q);

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  assign trap     = is_misaligned(req_size, req_addr[1:0]);
  assign resp_err = (state == ST_RESP) && err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= trap;
  end
`else
  assign trap     = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = trap ? ST_RESP : ST_ACCESS;
      ST_ACCESS: next_state = (we_q && is_subword(size_q)) ? ST_MERGE : ST_RESP;
      ST_MERGE:  next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Request fields are frozen at accept; ACCESS captures both the load result and the RMW old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      sign_q  <= req_signed;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == ST_ACCESS) begin
      old_q   <= mem_rd;
      rdata_q <= we_q ? 32'd0 : lane_rdata;
    end
  end

  lsu_lane u_lane (
    .rd       (mem_rd),
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .sign_ext (sign_q),
    .old_word (old_q),
    .wdata    (wdata_q),
    .rdata    (lane_rdata),
    .merged   (lane_merged)
  );

  // Reset gates mem_we directly so an aborted RMW can never commit a write.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    resp_rdata = (state == ST_RESP) ? rdata_q : 32'd0;
    mem_we     = 1'b0;
    mem_a      = '0;
    mem_wd     = 32'd0;
    case (state)
      ST_ACCESS: begin
        mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_we = word_store && !reset;
        mem_wd = word_store ? wdata_q : 32'd0;
      end
      ST_MERGE: begin
        mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_we = !reset;
        mem_wd = lane_merged;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu with a word memory and a byte-level reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_init = 1'b1;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  int checks = 0;
  int failures = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  mem_lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h9E3779B9 * (i + 1);
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and compares the full response against the reference model.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          idx;
    int          sh;
    int          exp_lat;
    int          exp_we_at;
    int          lat;
    int          we_cycles;
    int          we_at;
    int          a_active;
    bit          mis;
    bit          is_word;
    logic [31:0] old;
    logic [31:0] v;
    logic [31:0] mask;
    logic [31:0] exp_rdata;
    logic [31:0] exp_word;
    logic [31:0] wd_seen;
    logic [31:0] a_seen;
    logic [31:0] got_rdata;
    logic        got_err;

    idx      = int'(addr[7:2]);
    old      = ref_mem[idx];
    is_word  = size[1];
    mis      = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = ((size == 2'b01) && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`endif
    exp_word  = old;
    exp_rdata = 32'd0;
    exp_we_at = 0;
    if (mis) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      if (size == 2'b00) begin
        sh = int'(addr[1:0]) * 8;
        v  = (old >> sh) & 32'hFF;
        if (sgn && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2'b01) begin
        sh = int'(addr[1]) * 16;
        v  = (old >> sh) & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v - 32'h10000;
      end else begin
        v = old;
      end
      exp_rdata = v;
    end else if (is_word) begin
      exp_lat   = 2;
      exp_we_at = 1;
      exp_word  = wdata;
    end else begin
      exp_lat   = 3;
      exp_we_at = 2;
      sh        = (size == 2'b00) ? int'(addr[1:0]) * 8 : int'(addr[1]) * 16;
      mask      = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      exp_word  = (old & ~mask) | ((wdata << sh) & mask);
    end

    @(negedge clk);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    lat = 0; we_cycles = 0; we_at = 0; a_active = 0;
    wd_seen = 32'd0; a_seen = 32'd0; got_rdata = 32'd0; got_err = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_a != 32'd0) a_active++;
      if (mem_we) begin
        we_cycles++;
        we_at   = k;
        wd_seen = mem_wd;
        a_seen  = mem_a;
      end
      if (resp_valid) begin
        lat       = k;
        got_rdata = resp_rdata;
        got_err   = resp_err;
        break;
      end
    end

    check("resp_latency", lat, exp_lat);
    check("resp_rdata", got_rdata, exp_rdata);
    check("resp_err", {31'd0, got_err}, {31'd0, mis});
    check("mem_we_cycles", we_cycles, (exp_we_at != 0) ? 1 : 0);
    if (exp_we_at != 0) begin
      check("mem_we_cycle", we_at, exp_we_at);
      check("mem_wd", wd_seen, exp_word);
      check("mem_a", a_seen, {addr[31:2], 2'b00});
    end
    if (mis) check("trap_mem_a_idle", a_active, 0);

    @(negedge clk);
    check("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
    check("rdata_cleared", resp_rdata, 32'd0);
    ref_mem[idx] = exp_word;
    check("mem_contents", mem[idx], ref_mem[idx]);
    last_rdata = got_rdata;
    last_err   = got_err;
    last_lat   = lat;
  endtask

  initial begin
    int pulses;
    int pulse_at [2];
    int ready_low;
    int rsp_cnt;
    logic [31:0] hs_rdata [2];

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h9E3779B9 * (i + 1);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    reset    = 1'b0;
    mem_init = 1'b0;

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("plan_word_load", last_rdata, 32'hDEADBEEF);
    check("plan_word_lat", last_lat, 2);

    // Signed/unsigned sub-word loads.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("plan_sbyte", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("plan_ubyte", last_rdata, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("plan_shalf", last_rdata, 32'hFFFF80FF);

    // Byte read-modify-write.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
    check("plan_rmw_lat", last_lat, 3);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("plan_rmw_load", last_rdata, 32'h1122AA44);

    // Handshake with req_valid held across two word loads.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
    pulses = 0; ready_low = 0;
    pulse_at[0] = -1; pulse_at[1] = -1;
    hs_rdata[0] = 32'd0; hs_rdata[1] = 32'd0;
    for (int i = 0; i <= 6; i++) begin
      if (i <= 3 && !req_ready) ready_low++;
      if (resp_valid) begin
        if (pulses < 2) begin
          pulse_at[pulses] = i;
          hs_rdata[pulses] = resp_rdata;
        end
        pulses++;
      end
      if (i == 4) req_valid = 1'b0;
      @(negedge clk);
    end
    check("hs_pulses", pulses, 2);
    check("hs_first_at", pulse_at[0], 2);
    check("hs_second_at", pulse_at[1], 5);
    check("hs_ready_low", ready_low, 2);
    check("hs_rdata0", hs_rdata[0], 32'h80FF7F01);
    check("hs_rdata1", hs_rdata[1], 32'h80FF7F01);

    // Reset in the middle of a half-word RMW.
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h55555555);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h30; req_wdata = 32'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_access_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("rmw_merge_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_drops_we", {31'd0, mem_we}, 32'd0);
    rsp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) rsp_cnt++;
      if (i == 2) reset = 1'b0;
    end
    check("rst_no_resp", rsp_cnt, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("rst_mem_kept", last_rdata, 32'h55555555);

`ifdef MISALIGN_TRAP_EN
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    check("trap_err", {31'd0, last_err}, 32'd1);
    check("trap_lat", last_lat, 1);
    check("trap_rdata", last_rdata, 32'd0);
`endif

    // Randomized requests against the reference model.
    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Initiator-side load/store unit that drives the word-only data memory port (we, a, wd, rd) on behalf of the multicycle core.
- Accepts byte/halfword/word load and store requests over a valid/ready handshake.
- Performs lane extraction and sign/zero extension on loads.
- Implements sub-word stores as a read-modify-write, because the memory only writes whole words.

Parameters:
ADDR_W, 32, width of request and memory address buses.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse, no backpressure
resp_rdata  output  32  extended load data; 0 for stores
resp_err  output  1  misalignment trap (feature only; tied 0 otherwise)
mem_we  output  1  memory write enable
mem_a  output  ADDR_W  memory address, {addr[ADDR_W-1:2],2'b00}
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data, combinational from mem_a

Behaviour:
- States: IDLE, ACCESS, MERGE, RESP. Reset → IDLE.
- Reset values: req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_a=0; mem_wd=0.
- Handshake:
  - Accept on the rising edge where req_valid && req_ready.
  - Latch we, size, signed, addr and wdata at that edge.
  - req_ready is 0 in all states other than IDLE.
  - Request inputs are ignored outside IDLE.
- Transitions:
  - IDLE → ACCESS on accept.
  - ACCESS, load: capture extracted mem_rd at the end of the cycle → RESP.
  - ACCESS, word store: mem_we=1, mem_wd=wdata, memory writes at the closing edge → RESP.
  - ACCESS, byte/half store: mem_we=0; latch mem_rd as the old word → MERGE.
  - MERGE: mem_we=1; mem_wd = old word with the target lanes replaced → RESP.
  - RESP: resp_valid=1 for exactly one cycle → IDLE.
- Latency, counted from accept edge T:
  - Load and word store: resp_valid high in cycle T+2.
  - Sub-word store: resp_valid high in cycle T+3.
  - Back-to-back throughput: one request per 3 cycles, or per 4 cycles for sub-word stores.
- Lane rules (little-endian):
  - Byte lane = addr[1:0] (lane 0 = bits [7:0]).
  - Half lane = addr[1] (0 → [15:0], 1 → [31:16]).
  - Word ignores addr[1:0].
  - Without the feature, misaligned half/word accesses silently use these rules; addr[0] is ignored for half.
- mem_we is decoded from registered state only. It is 0 in IDLE and RESP.
- mem_a and mem_wd are 0 outside ACCESS/MERGE.
- resp_rdata holds its value only during RESP and is 0 otherwise.
- Reset mid-operation:
  - Asserting reset in ACCESS or MERGE drops mem_we combinationally, so no memory write occurs at the next edge.
  - A partially completed RMW leaves memory unmodified.
  - No response is issued for the aborted request.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half request with addr[0]=1, or a word request with addr[1:0]≠0, goes IDLE → RESP directly.
  - resp_err=1, resp_rdata=0.
  - No ACCESS/MERGE cycles and mem_we is never asserted; response arrives at T+1.
- Undefined: resp_err is tied 0 and misaligned requests follow the lane rules above.

Decomposition:
- Package mem_lsu_pkg contains:
  - Size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State encoding constants.
- Sub-module lsu_lane (combinational), containing:
  - Load path: extract and extend (rd word, size, lane, signed → rdata).
  - Store path: merge (old word, wdata, size, lane → new word).
- Instantiated once in mem_lsu; keeps the FSM file small.

Test Plan:
- Word store then load: store 0xDEADBEEF to addr 0x10, then load the word from 0x10.
  → resp_rdata=0xDEADBEEF at T+2; mem_we high exactly one cycle.
- Signed/unsigned byte load: memory word at 0x10 is 0x80FF7F01.
  → Signed byte at 0x13 gives 0xFFFFFF80.
  → Unsigned byte at 0x13 gives 0x00000080.
  → Signed half at 0x12 gives 0xFFFF80FF.
- Byte RMW: word at 0x20 is 0x11223344; store byte 0xAA to 0x21.
  → mem_we only in the MERGE cycle with mem_wd=0x1122AA44.
  → resp_valid at T+3; a later word load returns 0x1122AA44.
- Handshake: hold req_valid high continuously for two word loads.
  → Second accepted only after RESP (req_ready low for 2 cycles).
  → Exactly two resp_valid pulses, 3 cycles apart.
- Reset mid-RMW: pre-load 0x55555555 at 0x30, then issue a half store of 0x1234 to 0x30.
  → Assert reset during MERGE: mem_we drops at once and no resp_valid is issued.
  → After reset release, a load of 0x30 returns 0x55555555.
- With MISALIGN_TRAP_EN: word load from 0x06.
  → resp_valid and resp_err both high at T+1; resp_rdata=0.
  → mem_we and mem_a stay 0 throughout.
